pipelined_adder: RTL

Parametrised, pipelined successor to the 6-bit combinational ripple adder. Operands are split into CHUNK-bit slices, and one slice is added per pipeline stage with the carry registered between stages. Supports add or subtract per transaction and a carry-in. Valid/ready handshakes on both sides give full throughput under backpressure. It sits between operand producers and result consumers in the datapath and replaces the flat adder where timing requires it.

---
 rtl/adder_pkg.sv | 18 +
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/adder_chunk_stage.sv | 67 ++++++
 rtl/pipelined_adder.sv | 79 +++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the chunked pipelined adder.
// Computes the stage count and per-stage slice geometry from WIDTH and CHUNK.
package adder_pkg;

    function automatic int num_stages(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // The top slice absorbs the remainder when WIDTH is not a multiple of CHUNK.
    function automatic int slice_width(input int width, input int chunk, input int k);
        return (k == num_stages(width, chunk) - 1) ? (width - k * chunk) : chunk;
    endfunction

    function automatic int slice_offset(input int chunk, input int k);
        return k * chunk;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master is the producer/consumer side; slave is the adder itself.
interface pipelined_adder_if #(
    parameter int WIDTH = 6
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, s
    );

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, s
    );

endinterface

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: adds a single operand slice with the incoming carry
// and registers the partial sum, carry and remaining operand bits.
module adder_chunk_stage #(
    parameter int WIDTH  = 6,
    parameter int SLICE  = 2,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    input  logic [WIDTH-1:0] up_x,
    input  logic [WIDTH-1:0] up_y,
    output logic             valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] x_hi,
    output logic [WIDTH-1:0] y_hi
);

    typedef struct packed {
        logic [WIDTH-1:0] sum_lo;
        logic             carry;
        logic [WIDTH-1:0] x_hi;
        logic [WIDTH-1:0] y_hi;
    } payload_t;

    payload_t       pay_d;
    payload_t       pay_q;
    logic           valid_q;
    logic [SLICE:0] slice_res;

    // Consumed operand bits are cleared so only the unprocessed upper slices travel on.
    always_comb begin
        slice_res = {1'b0, up_x[OFFSET +: SLICE]}
                  + {1'b0, up_y[OFFSET +: SLICE]}
                  + {{SLICE{1'b0}}, up_carry};
        pay_d = '{sum_lo: up_sum, carry: slice_res[SLICE], x_hi: up_x, y_hi: up_y};
        pay_d.sum_lo[OFFSET +: SLICE] = slice_res[SLICE-1:0];
        pay_d.x_hi[OFFSET +: SLICE]   = '0;
        pay_d.y_hi[OFFSET +: SLICE]   = '0;
    end

    assign up_ready = !valid_q || down_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                pay_q <= pay_d;
            end
        end
    end

    assign valid = valid_q;
    assign sum   = pay_q.sum_lo;
    assign carry = pay_q.carry;
    assign x_hi  = pay_q.x_hi;
    assign y_hi  = pay_q.y_hi;

endmodule

// File: rtl/pipelined_adder.sv
// Elastic pipelined adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, valid/ready on both sides.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_adder_if.slave   bus
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);

    logic             valid_v [STAGES+1];
    logic [WIDTH-1:0] sum_v   [STAGES+1];
    logic             carry_v [STAGES+1];
    logic [WIDTH-1:0] x_v     [STAGES+1];
    logic [WIDTH-1:0] y_v     [STAGES+1];
    logic [STAGES-1:0] valid_bits;
    logic [STAGES-1:0] ready_bits;
    logic              unused_tail;

    assign valid_v[0] = bus.in_valid;
    assign sum_v[0]   = '0;
    assign carry_v[0] = bus.cin;
    assign x_v[0]     = bus.x;
    assign y_v[0]     = bus.sub ? ~bus.y : bus.y;

    always_comb begin
        valid_bits = '0;
        for (int i = 0; i < STAGES; i++) begin
            valid_bits[i] = valid_v[i+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW  = slice_width(WIDTH, CHUNK, k);
        localparam int OFF = slice_offset(CHUNK, k);

        logic down_ready;

        // Unrolled ready chain: a stage may advance unless every stage above it is full and stalled.
        if (k == STAGES - 1) begin : g_tail
            assign down_ready = bus.out_ready;
        end else begin : g_body
            assign down_ready = bus.out_ready || !(&valid_bits[STAGES-1:k+1]);
        end

        adder_chunk_stage #(
            .WIDTH  (WIDTH),
            .SLICE  (SW),
            .OFFSET (OFF)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (valid_v[k]),
            .up_ready   (ready_bits[k]),
            .up_sum     (sum_v[k]),
            .up_carry   (carry_v[k]),
            .up_x       (x_v[k]),
            .up_y       (y_v[k]),
            .valid      (valid_v[k+1]),
            .down_ready (down_ready),
            .sum        (sum_v[k+1]),
            .carry      (carry_v[k+1]),
            .x_hi       (x_v[k+1]),
            .y_hi       (y_v[k+1])
        );
    end

    assign bus.in_ready  = ready_bits[0];
    assign bus.out_valid = valid_v[STAGES];
    assign bus.s         = {carry_v[STAGES], sum_v[STAGES]};

    assign unused_tail = ^{ready_bits, x_v[STAGES], y_v[STAGES]};

endmodule
